// File: rtl/magia_tile_barrier_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : magia_tile_barrier_ctrl
// Brief    : Multi-tile hardware barrier. It collects arrivals and sleep status
//            from the participating tiles, then wakes them all with a single
//            one-cycle wu_wfe_o pulse. The optional timeout path is enabled by
//            defining MAGIA_BARRIER_TIMEOUT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module magia_tile_barrier_ctrl #(
    parameter int N_TILES = 4,
    parameter int CNT_W   = 16,
    parameter int TO_W    = 20
) (
    input  logic               clk_i,
    input  logic               rstn_i,
    input  logic               enable_i,
    input  logic [N_TILES-1:0] mask_i,
    input  logic [N_TILES-1:0] arrive_i,
    input  logic [N_TILES-1:0] sleep_i,
    output logic [N_TILES-1:0] wu_wfe_o,
    output logic               done_o,
    output logic               busy_o,
    output logic [N_TILES-1:0] arrived_o,
    output logic [CNT_W-1:0]   barrier_cnt_o,
    input  logic [TO_W-1:0]    timeout_i,
    output logic               error_o
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COLLECT = 2'd1,
        ST_RELEASE = 2'd2,
        ST_DRAIN   = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] c_cnt_one = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t             r_state;
    state_t             w_state_nxt;
    logic [N_TILES-1:0] r_mask_q;
    logic [N_TILES-1:0] w_mask_nxt;
    logic [N_TILES-1:0] r_arrived;
    logic [N_TILES-1:0] w_arrived_nxt;
    logic [N_TILES-1:0] r_woke;
    logic [N_TILES-1:0] w_woke_nxt;
    logic [N_TILES-1:0] r_wake_set;
    logic [N_TILES-1:0] w_wake_set_nxt;
    logic [N_TILES-1:0] r_wu;
    logic [N_TILES-1:0] w_wu_nxt;
    logic               r_done;
    logic               w_done_nxt;
    logic [CNT_W-1:0]   r_cnt;
    logic [CNT_W-1:0]   w_cnt_nxt;

    logic [N_TILES-1:0] w_col_arr;
    logic [N_TILES-1:0] w_drain_woke;
    logic               w_release_ok;
    logic               w_timeout_hit;

    // Arrivals seen so far including this cycle, and wake-ups seen so far including this cycle
    assign w_col_arr    = r_arrived | (arrive_i & r_mask_q);
    assign w_drain_woke = r_woke | (~sleep_i & r_wake_set);
    assign w_release_ok = (r_state == ST_COLLECT)
                       && (w_col_arr == r_mask_q)
                       && ((sleep_i & r_mask_q) == r_mask_q);

`ifdef MAGIA_BARRIER_TIMEOUT_EN
    localparam logic [TO_W-1:0] c_to_one = {{(TO_W-1){1'b0}}, 1'b1};

    logic [TO_W-1:0] r_to_cnt;
    logic            r_error;
    logic            w_forced;

    assign w_timeout_hit = (r_state == ST_COLLECT)
                        && (timeout_i != '0)
                        && ((r_to_cnt + c_to_one) == timeout_i);
    assign w_forced      = w_timeout_hit && !w_release_ok;

    // Counter only advances while staying in COLLECT, so every entry starts from zero
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_to_cnt <= '0;
            r_error  <= 1'b0;
        end else if (!enable_i) begin
            r_to_cnt <= '0;
            r_error  <= 1'b0;
        end else begin
            if ((r_state == ST_COLLECT) && (w_state_nxt == ST_COLLECT)) begin
                r_to_cnt <= r_to_cnt + c_to_one;
            end else begin
                r_to_cnt <= '0;
            end
            if (w_forced) begin
                r_error <= 1'b1;
            end
        end
    end

    assign error_o = r_error;
`else
    logic w_unused_timeout;

    assign w_unused_timeout = ^timeout_i;
    assign w_timeout_hit    = 1'b0;
    assign error_o          = 1'b0;
`endif

    always_comb begin
        w_state_nxt    = r_state;
        w_mask_nxt     = r_mask_q;
        w_arrived_nxt  = r_arrived;
        w_woke_nxt     = r_woke;
        w_wake_set_nxt = r_wake_set;
        w_wu_nxt       = '0;
        w_done_nxt     = 1'b0;
        w_cnt_nxt      = r_cnt;

        if (!enable_i) begin
            w_state_nxt    = ST_IDLE;
            w_mask_nxt     = '0;
            w_arrived_nxt  = '0;
            w_woke_nxt     = '0;
            w_wake_set_nxt = '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if ((arrive_i & mask_i) != '0) begin
                        w_mask_nxt    = mask_i;
                        w_arrived_nxt = arrive_i & mask_i;
                        w_state_nxt   = ST_COLLECT;
                    end
                end
                ST_COLLECT: begin
                    w_arrived_nxt = w_col_arr;
                    if (w_release_ok || w_timeout_hit) begin
                        // A forced release only wakes the tiles that actually arrived
                        w_wake_set_nxt = w_release_ok ? r_mask_q : w_col_arr;
                        w_wu_nxt       = w_wake_set_nxt;
                        w_done_nxt     = 1'b1;
                        w_cnt_nxt      = r_cnt + c_cnt_one;
                        w_arrived_nxt  = '0;
                        w_woke_nxt     = '0;
                        w_state_nxt    = ST_RELEASE;
                    end
                end
                ST_RELEASE: begin
                    w_state_nxt = ST_DRAIN;
                end
                ST_DRAIN: begin
                    w_woke_nxt    = w_drain_woke;
                    w_arrived_nxt = r_arrived | (arrive_i & r_mask_q);
                    if (w_drain_woke == r_wake_set) begin
                        w_state_nxt = (w_arrived_nxt != '0) ? ST_COLLECT : ST_IDLE;
                    end
                end
                default: begin
                    w_state_nxt = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_state    <= ST_IDLE;
            r_mask_q   <= '0;
            r_arrived  <= '0;
            r_woke     <= '0;
            r_wake_set <= '0;
            r_wu       <= '0;
            r_done     <= 1'b0;
            r_cnt      <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_mask_q   <= w_mask_nxt;
            r_arrived  <= w_arrived_nxt;
            r_woke     <= w_woke_nxt;
            r_wake_set <= w_wake_set_nxt;
            r_wu       <= w_wu_nxt;
            r_done     <= w_done_nxt;
            r_cnt      <= w_cnt_nxt;
        end
    end

    assign wu_wfe_o      = r_wu;
    assign done_o        = r_done;
    assign busy_o        = (r_state != ST_IDLE);
    assign arrived_o     = r_arrived;
    assign barrier_cnt_o = r_cnt;

endmodule
`default_nettype wire
